// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the spi_0 register-port bridge.
//   state_e    : bus-master FSM states
//   ADDR_*     : spi_0 register addresses used (or deliberately avoided)
//   ACCESS_LEN : cycles per bus access (address/strobe/data held constant)
//   rx_entry_t : RX FIFO word, EOP flag alongside the received data
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_INIT0,
        ST_INIT1,
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_WR0,
        ST_WR1
    } state_e;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

    localparam int unsigned ACCESS_LEN = 2;

    typedef struct packed {
        logic        eop;
        logic [31:0] data;
    } rx_entry_t;

endpackage

// File: rtl/spi_bridge_rx_fifo.sv
// Synchronous FIFO for received words (default 33 bits: EOP flag + data).
//   clk, reset_n : clock and asynchronous active-low reset (empties the FIFO)
//   push, push_data : write request and word
//   pop          : read request (ignored while empty)
//   head_data    : word at the read pointer
//   count        : occupancy, $clog2(DEPTH)+1 bits
//   full, empty  : occupancy flags
module spi_bridge_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A pop frees the slot this cycle, so push-while-full is legal alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_stream_bridge.sv
// Autonomous bus master for the spi_0 slave register port.
// Programs EOP_VALUE into address 6 after reset, drains received words from
// address 0 into an RX FIFO (valid/ready stream with EOP flag) and writes
// words from the TX stream into address 1 when the slave is ready.
//   clk, reset_n                 : clock (shared with spi_0), async active-low reset
//   spi_select, mem_addr, read_n,
//   write_n, data_from_cpu       : registered bus outputs to spi_0
//   data_to_cpu, dataavailable,
//   readyfordata                 : spi_0 read data, RRDY, TRDY
//   rx_data, rx_eop, rx_valid,
//   rx_ready                     : RX stream out of the FIFO
//   tx_data, tx_valid, tx_ready  : TX stream in; tx_ready is a one-cycle accept
//   init_done                    : sticky, set once EOP_VALUE is programmed
module spi_slave_stream_bridge
    import spi_bridge_pkg::*;
#(
    parameter logic [31:0] EOP_VALUE = 32'h0000_00FF,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        spi_select,
    output logic [2:0]  mem_addr,
    output logic        read_n,
    output logic        write_n,
    output logic [31:0] data_from_cpu,
    input  logic [31:0] data_to_cpu,
    input  logic        dataavailable,
    input  logic        readyfordata,
    output logic [31:0] rx_data,
    output logic        rx_eop,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        init_done
);

    localparam int unsigned CNT_W = $clog2(RX_DEPTH) + 1;

    state_e      state_q, state_d;
    logic        spi_select_q, spi_select_d;
    logic        read_n_q, read_n_d;
    logic        write_n_q, write_n_d;
    logic [2:0]  mem_addr_q, mem_addr_d;
    logic [31:0] data_q, data_d;
    logic        init_done_q, init_done_d;

    logic        tx_accept;
    logic        fifo_push;
    logic        fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    rx_entry_t   fifo_in, fifo_head;
    logic        rd_go;

    assign rd_go = dataavailable & ~fifo_full;

    // Bus outputs are registered from the next-state decode so the strobes
    // line up with the state they belong to. INIT0 holds for one extra cycle
    // (until spi_select_q is up) so the EOP write still spans both init cycles
    // even though the output registers come out of reset idle.
    always_comb begin
        state_d      = state_q;
        spi_select_d = 1'b0;
        read_n_d     = 1'b1;
        write_n_d    = 1'b1;
        mem_addr_d   = mem_addr_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        tx_accept    = 1'b0;
        fifo_push    = 1'b0;

        case (state_q)
            ST_INIT0: state_d = spi_select_q ? ST_INIT1 : ST_INIT0;
            ST_INIT1: begin
                state_d     = ST_IDLE;
                init_done_d = 1'b1;
            end
            ST_IDLE: begin
                if (rd_go) begin
                    state_d = ST_RD0;
                end else if (readyfordata && tx_valid) begin
                    tx_accept = 1'b1;
                    data_d    = tx_data;
                    state_d   = ST_WR0;
                end
            end
            ST_RD0:  state_d = ST_RD1;
            ST_RD1: begin
                fifo_push = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_WR0:  state_d = ST_WR1;
            ST_WR1:  state_d = ST_IDLE;
            default: state_d = ST_INIT0;
        endcase

        case (state_d)
            ST_INIT0, ST_INIT1: begin
                spi_select_d = 1'b1;
                write_n_d    = 1'b0;
                mem_addr_d   = ADDR_EOPVAL;
                data_d       = EOP_VALUE;
            end
            ST_RD0, ST_RD1: begin
                spi_select_d = 1'b1;
                read_n_d     = 1'b0;
                mem_addr_d   = ADDR_RXDATA;
            end
            ST_WR0, ST_WR1: begin
                spi_select_d = 1'b1;
                write_n_d    = 1'b0;
                mem_addr_d   = ADDR_TXDATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT0;
            spi_select_q <= 1'b0;
            read_n_q     <= 1'b1;
            write_n_q    <= 1'b1;
            mem_addr_q   <= '0;
            data_q       <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            spi_select_q <= spi_select_d;
            read_n_q     <= read_n_d;
            write_n_q    <= write_n_d;
            mem_addr_q   <= mem_addr_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
        end
    end

    // data_to_cpu is registered inside spi_0, so it is valid in RD1 after
    // address 0 was presented during RD0.
    assign fifo_in.eop  = (data_to_cpu == EOP_VALUE);
    assign fifo_in.data = data_to_cpu;

    spi_bridge_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (33)
    ) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (rx_valid & rx_ready),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The RD0-entry full check must be enough to keep the FIFO from overrunning.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        fifo_count <= CNT_W'(RX_DEPTH));

    assign spi_select    = spi_select_q;
    assign read_n        = read_n_q;
    assign write_n       = write_n_q;
    assign mem_addr      = mem_addr_q;
    assign data_from_cpu = data_q;
    assign init_done     = init_done_q;
    assign tx_ready      = tx_accept;
    assign rx_valid      = ~fifo_empty;
    assign rx_data       = fifo_head.data;
    assign rx_eop        = fifo_head.eop & ~fifo_empty;

endmodule

// File: tb/tb_spi_slave_stream_bridge.sv
module tb_spi_slave_stream_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu = '0;
    logic        dataavailable = 1'b0;
    logic        readyfordata = 1'b1;
    logic [31:0] rx_data;
    logic        rx_eop;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        init_done;

    int total = 0;
    int bad   = 0;

    // spi_0 register-port model state
    logic [31:0] rxq [$];
    logic [31:0] rx_hold = '0;
    logic [1:0]  run = '0;
    logic [2:0]  acc_addr = '0;
    logic [31:0] acc_data = '0;
    logic        acc_rd = 1'b0;
    int          trdy_cnt = 0;
    int          n_reads = 0;
    int          n_wr1 = 0;
    int          n_eop_wr = 0;
    int          proto_err = 0;
    logic [31:0] last_wr1_data = '0;
    logic [31:0] last_eop_data = '0;
    logic [31:0] last_pop = '0;

    always #5 clk = ~clk;

    spi_slave_stream_bridge #(
        .EOP_VALUE (32'h0000_00FF),
        .RX_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata),
        .rx_data       (rx_data),
        .rx_eop        (rx_eop),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .init_done     (init_done)
    );

    // spi_0 model: registered read data, two-cycle accesses acted on at the
    // end of the second cycle, RRDY cleared by a read, TRDY low after a write.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run           <= '0;
            dataavailable <= 1'b0;
            readyfordata  <= 1'b1;
            trdy_cnt      <= 0;
            data_to_cpu   <= '0;
        end else begin
            data_to_cpu <= (mem_addr == 3'd0) ? rx_hold : 32'h0;
            if (trdy_cnt != 0) begin
                trdy_cnt <= trdy_cnt - 1;
                if (trdy_cnt == 1) readyfordata <= 1'b1;
            end
            if (spi_select && (!read_n || !write_n)) begin
                if (run == 2'd0) begin
                    run      <= 2'd1;
                    acc_addr <= mem_addr;
                    acc_data <= data_from_cpu;
                    acc_rd   <= !read_n;
                end else if (run == 2'd1) begin
                    run <= 2'd2;
                    if (mem_addr !== acc_addr || data_from_cpu !== acc_data ||
                        (!read_n) !== acc_rd || (!read_n && !write_n))
                        proto_err <= proto_err + 1;
                    if (!read_n) begin
                        if (mem_addr == 3'd0 && dataavailable) begin
                            n_reads       <= n_reads + 1;
                            dataavailable <= 1'b0;
                        end else begin
                            proto_err <= proto_err + 1;
                        end
                    end else begin
                        case (mem_addr)
                            3'd1: begin
                                if (!readyfordata) proto_err <= proto_err + 1;
                                n_wr1         <= n_wr1 + 1;
                                last_wr1_data <= data_from_cpu;
                                readyfordata  <= 1'b0;
                                trdy_cnt      <= 3;
                            end
                            3'd6: begin
                                n_eop_wr      <= n_eop_wr + 1;
                                last_eop_data <= data_from_cpu;
                            end
                            default: proto_err <= proto_err + 1;
                        endcase
                    end
                end else begin
                    proto_err <= proto_err + 1;
                end
            end else begin
                run <= 2'd0;
            end
            if (!dataavailable && rxq.size() > 0) begin
                rx_hold       <= rxq.pop_front();
                dataavailable <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && rx_valid && rx_ready) last_pop <= rx_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        int reads0;
        int wr0;
        logic found;

        // ---- reset values ----
        tx_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_select",  spi_select, 1'b0);
        chk("rst_read_n",  read_n, 1'b1);
        chk("rst_write_n", write_n, 1'b1);
        chk("rst_addr",    mem_addr, 3'd0);
        chk("rst_wdata",   data_from_cpu, 32'h0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_eop",  rx_eop, 1'b0);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        tx_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // ---- init sequence: two write cycles at address 6 ----
        @(negedge clk);
        chk("init_c0", {spi_select, write_n, read_n, mem_addr, data_from_cpu},
            {1'b1, 1'b0, 1'b1, 3'd6, 32'h0000_00FF});
        chk("init_c0_done", init_done, 1'b0);
        @(negedge clk);
        chk("init_c1", {spi_select, write_n, read_n, mem_addr, data_from_cpu},
            {1'b1, 1'b0, 1'b1, 3'd6, 32'h0000_00FF});
        @(negedge clk);
        chk("init_idle", {spi_select, write_n, read_n}, {1'b0, 1'b1, 1'b1});
        chk("init_done", init_done, 1'b1);
        chk("init_eop_writes", n_eop_wr, 1);
        chk("init_eop_data", last_eop_data, 32'h0000_00FF);

        // ---- single word, downstream ready ----
        rx_ready = 1'b1;
        rxq.push_back(32'h1234_5678);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (rx_valid) found = 1'b1;
        end
        chk("rx1_seen", found, 1'b1);
        chk("rx1_data", rx_data, 32'h1234_5678);
        chk("rx1_eop", rx_eop, 1'b0);
        @(negedge clk);
        chk("rx1_valid_1cyc", rx_valid, 1'b0);
        chk("rx1_reads", n_reads, 1);

        // ---- EOP word ----
        rxq.push_back(32'h0000_00FF);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (rx_valid) found = 1'b1;
        end
        chk("eop_seen", found, 1'b1);
        chk("eop_data", rx_data, 32'h0000_00FF);
        chk("eop_flag", rx_eop, 1'b1);
        @(negedge clk);

        // ---- FIFO fills, no read while full ----
        rx_ready = 1'b0;
        reads0 = n_reads;
        for (int i = 1; i <= 5; i++) rxq.push_back(32'hA000_0000 + 32'(i));
        repeat (40) @(negedge clk);
        chk("full_reads", n_reads - reads0, 4);
        chk("full_rrdy_pending", dataavailable, 1'b1);
        chk("full_head", {rx_valid, rx_data}, {1'b1, 32'hA000_0001});
        pop_one();
        repeat (12) @(negedge clk);
        chk("full_fifth_read", n_reads - reads0, 5);
        for (int i = 2; i <= 5; i++) begin
            chk("order_data", {rx_valid, rx_data}, {1'b1, 32'hA000_0000 + 32'(i)});
            pop_one();
        end
        chk("order_empty", rx_valid, 1'b0);

        // ---- RX has priority over a simultaneous TX offer ----
        rx_ready = 1'b1;
        rxq.push_back(32'h55AA_0001);
        @(negedge clk);
        reads0 = n_reads;
        wr0 = n_wr1;
        tx_data  = 32'hCAFE_F00D;
        tx_valid = 1'b1;
        #1;
        chk("prio_no_tx_yet", {dataavailable, readyfordata, tx_ready}, {1'b1, 1'b1, 1'b0});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx_ready) found = 1'b1;
        end
        chk("prio_tx_accept", found, 1'b1);
        chk("prio_read_first", n_reads - reads0, 1);
        @(negedge clk);
        chk("tx_ready_pulse", tx_ready, 1'b0);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("tx_writes", n_wr1 - wr0, 1);
        chk("tx_wdata", last_wr1_data, 32'hCAFE_F00D);
        chk("prio_rx_word", last_pop, 32'h55AA_0001);

        // ---- reset during RD1 ----
        rx_ready = 1'b0;
        rxq.push_back(32'h1111_1111);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (rx_valid) found = 1'b1;
        end
        chk("rr_preload", found, 1'b1);
        rxq.push_back(32'h2222_2222);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (!read_n) found = 1'b1;
        end
        chk("rr_rd0_seen", found, 1'b1);
        @(negedge clk);
        chk("rr_in_rd1", {spi_select, read_n, mem_addr}, {1'b1, 1'b0, 3'd0});
        reset_n = 1'b0;
        #1;
        chk("rr_strobes_off", {spi_select, read_n, write_n}, {1'b0, 1'b1, 1'b1});
        chk("rr_fifo_empty", rx_valid, 1'b0);
        chk("rr_init_cleared", init_done, 1'b0);
        rxq.delete();
        wr0 = n_eop_wr;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rr_reinit_c0", {spi_select, write_n, mem_addr, data_from_cpu},
            {1'b1, 1'b0, 3'd6, 32'h0000_00FF});
        @(negedge clk);
        @(negedge clk);
        chk("rr_reinit_done", {init_done, spi_select}, {1'b1, 1'b0});
        chk("rr_reinit_write", n_eop_wr - wr0, 1);
        chk("rr_still_empty", rx_valid, 1'b0);

        repeat (5) @(negedge clk);
        chk("bus_protocol_errors", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
